// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word requests on byte addresses become word accesses; sub-word stores use read-modify-write.
// Latency: load/word store 2 cycles to done, sub-word store 3, misaligned 1; req_ready only in IDLE, requests while busy are dropped.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_readData
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        wr_q, sgn_q, mis_q, mis_in, accept;
    logic [1:0]  size_q, off_q;
    logic [15:0] wdata_q;
    logic [31:0] merged, extracted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign accept = (state == S_IDLE) && req_valid;

    // size 2 and reserved 3 both behave as word
    always_comb begin
        mis_in = 1'b0;
        if (req_size == 2'd1)
            mis_in = req_addr[0];
        else if (req_size[1])
            mis_in = |req_addr[1:0];
    end

    always_ff @(posedge clock_in) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (mis_in)
                        state_nxt = S_DONE;
                    else if (req_write && req_size[1])
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = wr_q ? S_WR : S_DONE;
            S_WR:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        load_valid   = (state == S_DONE) && !wr_q && !mis_q;
        misaligned   = (state == S_DONE) && mis_q;
        mem_memRead  = (state == S_RD);
        mem_memWrite = (state == S_WR);
    end

    always_comb begin
        merged = mem_readData;
        if (size_q == 2'd0) begin
            unique case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        unique case (off_q)
            2'd0:    lane_b = mem_readData[7:0];
            2'd1:    lane_b = mem_readData[15:8];
            2'd2:    lane_b = mem_readData[23:16];
            default: lane_b = mem_readData[31:24];
        endcase
        lane_h = off_q[1] ? mem_readData[31:16] : mem_readData[15:0];
        if (size_q[1])
            extracted = mem_readData;
        else if (size_q[0])
            extracted = {{16{sgn_q & lane_h[15]}}, lane_h};
        else
            extracted = {{24{sgn_q & lane_b[7]}}, lane_b};
    end

    // The RD cycle's read word feeds either the store merge or the load result
    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_q          <= 1'b0;
            sgn_q         <= 1'b0;
            mis_q         <= 1'b0;
            size_q        <= 2'd0;
            off_q         <= 2'd0;
            wdata_q       <= 16'd0;
            mem_address   <= 32'd0;
            mem_writeData <= 32'd0;
            load_data     <= 32'd0;
        end else begin
            if (accept) begin
                wr_q        <= req_write;
                sgn_q       <= req_signed;
                mis_q       <= mis_in;
                size_q      <= req_size;
                off_q       <= req_addr[1:0];
                wdata_q     <= req_wdata[15:0];
                mem_address <= 32'(req_addr[ADDR_W-1:2]);
                if (req_write && req_size[1] && !mis_in)
                    mem_writeData <= req_wdata;
            end
            if (state == S_RD) begin
                if (wr_q)
                    mem_writeData <= merged;
                else
                    load_data <= extracted;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a 16-word memory preloaded with word i = i.
module tb_mem_access_unit;

    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, busy, done, load_valid, misaligned, mem_memWrite, mem_memRead;
    logic [31:0] load_data, mem_address, mem_writeData, mem_readData;

    logic [31:0] mem [16];
    logic        mem_init = 1'b0;
    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          a_last = 0;
    int          a_prev = 0;
    logic [31:0] held = 32'd0;

    typedef struct {
        logic        lv;
        logic        mis;
        logic [31:0] ld;
        int          k;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wexp_q[$];

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .busy          (busy),
        .done          (done),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .misaligned    (misaligned),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memWrite  (mem_memWrite),
        .mem_memRead   (mem_memRead),
        .mem_readData  (mem_readData)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    assign mem_readData = mem[mem_address[3:0]];

    always @(negedge clock_in) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
            mem_init <= 1'b1;
        end else if (mem_memWrite) begin
            mem[mem_address[3:0]] <= mem_writeData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic fail_evt(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Accept watcher: inputs are stable at the falling edge, the following rising edge accepts
    always @(negedge clock_in) begin
        if (!reset && req_valid && req_ready) begin
            a_prev = a_last;
            a_last = cyc + 1;
            n_acc++;
        end
    end

    always @(negedge clock_in) begin : monitor
        exp_t e;
        wr_t  w;
        if (done) begin
            if (exp_q.size() == 0) begin
                fail_evt("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                chk("load_valid", 32'(load_valid), 32'(e.lv));
                chk("misaligned", 32'(misaligned), 32'(e.mis));
                chk("load_data", load_data, e.ld);
                chk("done_cycle", 32'(cyc - a_last + 1), 32'(e.k));
            end
        end
        if (mem_memWrite) begin
            if (wexp_q.size() == 0) begin
                fail_evt("unexpected_write");
            end else begin
                w = wexp_q.pop_front();
                chk("wr_address", mem_address, w.a);
                chk("wr_data", mem_writeData, w.d);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clock_in); #1;
            t++;
        end
        if (!req_ready) fail_evt("ready_timeout");
    endtask

    task automatic push_exp(input logic lv, input logic mis, input logic [31:0] ld, input int k,
                            input logic dw, input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        wr_t  w;
        if (k > 0) begin
            if (lv) held = ld;
            e.lv = lv; e.mis = mis; e.ld = held; e.k = k;
            exp_q.push_back(e);
        end
        if (dw) begin
            w.a = wa; w.d = wd;
            wexp_q.push_back(w);
        end
    endtask

    // Issues one request and returns one time unit into cycle 1; k=0 means no completion expected
    task automatic req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wdat, input logic lv, input logic mis, input logic [31:0] ld,
                       input int k, input logic dw, input logic [31:0] wa, input logic [31:0] wd);
        wait_ready();
        push_exp(lv, mis, ld, k, dw, wa, wd);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wdat;
        req_valid = 1'b1;
        @(posedge clock_in); #1;
        req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int s;
        int t;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_read", 32'(mem_memRead), 32'd0);
        chk("rst_mem_write", 32'(mem_memWrite), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_write_data", mem_writeData, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        reset = 1'b0;
        @(posedge clock_in); #1;

        // word load at 0x14
        req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0000_0005, 2, 1'b0, 32'h0, 32'h0);
        chk("wl_mem_read_c1", 32'(mem_memRead), 32'd1);
        chk("wl_mem_address_c1", mem_address, 32'd5);
        chk("wl_busy_c1", 32'(busy), 32'd1);

        // byte store then byte loads
        req(1'b1, 2'd0, 1'b0, 32'h09, 32'hAB, 1'b0, 1'b0, 32'h0, 3, 1'b1, 32'd2, 32'h0000_AB02);
        req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 1'b1, 1'b0, 32'h0000_00AB, 2, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAB, 2, 1'b0, 32'h0, 32'h0);

        // half store then half and word loads
        req(1'b1, 2'd1, 1'b0, 32'h0E, 32'h8001, 1'b0, 1'b0, 32'h0, 3, 1'b1, 32'd3, 32'h8001_0003);
        req(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001, 2, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 1'b1, 1'b0, 32'h0000_8001, 2, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h8001_0003, 2, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd0, 1'b1, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h0000_0003, 2, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 2, 1'b0, 32'h0, 32'h0);

        // misaligned word load, misaligned half store, reserved size as misaligned word
        req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0);
        chk("mis_flag_c1", 32'(misaligned), 32'd1);
        chk("mis_mem_read_c1", 32'(mem_memRead), 32'd0);
        chk("mis_mem_write_c1", 32'(mem_memWrite), 32'd0);
        @(posedge clock_in); #1;
        chk("mis_mem_read_c2", 32'(mem_memRead), 32'd0);
        chk("mis_ready_c2", 32'(req_ready), 32'd1);
        req(1'b1, 2'd1, 1'b0, 32'h05, 32'hDEAD, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0);
        req(1'b0, 2'd3, 1'b0, 32'h0D, 32'h0, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0);

        // reset in the RD cycle of a byte store
        req(1'b1, 2'd0, 1'b0, 32'h04, 32'hFF, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'h0);
        chk("abort_rd_c1", 32'(mem_memRead), 32'd1);
        reset = 1'b1;
        @(posedge clock_in); #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mem_read", 32'(mem_memRead), 32'd0);
        chk("abort_mem_write", 32'(mem_memWrite), 32'd0);
        chk("abort_mem_address", mem_address, 32'd0);
        chk("abort_write_data", mem_writeData, 32'd0);
        chk("abort_load_data", load_data, 32'd0);
        reset = 1'b0;
        held = 32'd0;
        req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 2, 1'b0, 32'h0, 32'h0);

        // req_valid held high across a word store and the following word load
        wait_ready();
        s = n_acc;
        push_exp(1'b0, 1'b0, 32'h0, 2, 1'b1, 32'd8, 32'h1234_5678);
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clock_in); #1;
        push_exp(1'b1, 1'b0, 32'h1234_5678, 2, 1'b0, 32'h0, 32'h0);
        req_write = 1'b0;
        t = 0;
        while (n_acc < s + 2 && t < 20) begin
            @(posedge clock_in); #1;
            t++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc - s), 32'd2);
        chk("b2b_spacing", 32'(a_last - a_prev), 32'd3);

        t = 0;
        while ((exp_q.size() != 0 || wexp_q.size() != 0) && t < 20) begin
            @(posedge clock_in); #1;
            t++;
        end
        chk("pending_done", 32'(exp_q.size()), 32'd0);
        chk("pending_write", 32'(wexp_q.size()), 32'd0);
        chk("b2b_no_extra", 32'(n_acc - s), 32'd2);
        @(posedge clock_in); #1;
        chk("mem_word1", mem[1], 32'h0000_0001);
        chk("mem_word2", mem[2], 32'h0000_AB02);
        chk("mem_word3", mem[3], 32'h8001_0003);
        chk("mem_word8", mem[8], 32'h1234_5678);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
